// File: rtl/param_sync_fifo.sv
// param_sync_fifo: synchronous FIFO with occupancy, threshold and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered reads.
module param_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   write,
    input  logic [WIDTH-1:0]       wrData,
    input  logic                   read,
    output logic [WIDTH-1:0]       rdData,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    w_ptr, r_ptr;
    logic             rd_acc, wr_acc;
    logic [CW-1:0]    count_next;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign almost_empty = count <= CW'(AE_LEVEL);

    // a write into a full FIFO is allowed only when a read frees a slot in the same cycle
    always_comb begin
        rd_acc     = read && !empty;
        wr_acc     = write && (!full || rd_acc);
        count_next = (wr_acc && !rd_acc) ? count + CW'(1) :
                     (rd_acc && !wr_acc) ? count - CW'(1) : count;
    end

    // storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc && !clr)
            mem[w_ptr] <= wrData;
    end

    // pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                w_ptr <= w_ptr + AW'(1);
            if (rd_acc)
                r_ptr <= r_ptr + AW'(1);
            count <= count_next;
            if (write && full && !read)
                overflow <= 1'b1;
            if (read && empty)
                underflow <= 1'b1;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign rdData   = mem[r_ptr];
    assign rd_valid = !empty;
`else
    // registered read port; rdData holds between accepted reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdData   <= '0;
            rd_valid <= 1'b0;
        end else if (clr) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc)
                rdData <= mem[r_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: randomized and directed checks of param_sync_fifo against a queue model
module tb_param_sync_fifo;
    localparam int D = 8;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif
    localparam logic [10:0] RST_ST  = 11'b0000_0101000;
    localparam logic [11:0] RST_ST2 = 12'b00000_0101000;

    logic        clk = 1'b0, rst = 1'b0, clr = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] wr_data = '0, rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;
    logic        clr2 = 1'b0, write2 = 1'b0, read2 = 1'b0;
    logic [7:0]  wr_data2 = '0, rd_data2;
    logic        rd_valid2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
    logic [4:0]  count2;
    logic [10:0] status;
    logic [11:0] status2;

    int tests = 0, fails = 0;
    logic [31:0] q[$];
    bit          ovf_m, unf_m, rv_m;
    logic [31:0] rd_m;

    assign status  = {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid};
    assign status2 = {count2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2, rd_valid2};

    always #5 clk = ~clk;

    param_sync_fifo u_dut (
        .clk(clk), .rst(rst), .clr(clr), .write(write), .wrData(wr_data), .read(read),
        .rdData(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u_dut16 (
        .clk(clk), .rst(rst), .clr(clr2), .write(write2), .wrData(wr_data2), .read(read2),
        .rdData(rd_data2), .rd_valid(rd_valid2), .full(full2), .empty(empty2),
        .almost_full(almost_full2), .almost_empty(almost_empty2), .count(count2),
        .overflow(overflow2), .underflow(underflow2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        ovf_m = 0;
        unf_m = 0;
        rv_m  = 0;
        rd_m  = '0;
    endtask

    function automatic logic [10:0] exp_status();
        int n = q.size();
        return {4'(n), n == D, n == 0, n >= D - 1, n <= 1, ovf_m, unf_m, rv_m};
    endfunction

    // one clock of stimulus on the default instance, with the model advanced by the FIFO rules
    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c);
        bit rok, wok;
        write = w; wr_data = d; read = r; clr = c;
        @(posedge clk);
        if (c) begin
            q.delete();
            ovf_m = 0;
            unf_m = 0;
            rv_m  = 0;
        end else begin
            rok = r && q.size() > 0;
            wok = w && (q.size() < D || rok);
            if (w && q.size() == D && !r) ovf_m = 1;
            if (r && q.size() == 0) unf_m = 1;
            rv_m = rok;
            if (rok) rd_m = q.pop_front();
            if (wok) q.push_back(d);
        end
        if (FWFT) begin
            rv_m = q.size() > 0;
            if (rv_m) rd_m = q[0];
        end
        #1;
        write = 0; read = 0; clr = 0;
    endtask

    task automatic step2(input bit w, input logic [7:0] d, input bit r);
        write2 = w; wr_data2 = d; read2 = r;
        @(posedge clk);
        #1;
        write2 = 0; read2 = 0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (status !== RST_ST || (!FWFT && rd_data !== 32'h0)) begin
            fails++;
            $display("FAIL reset_status got %b/%h want %b/0", status, rd_data, RST_ST);
        end
        tests++;
        if (status2 !== RST_ST2) begin
            fails++;
            $display("FAIL reset_status16 got %b want %b", status2, RST_ST2);
        end
        rst = 1;
        model_reset();
    endtask

    task automatic test_fill_drain();
        logic [31:0] want;
        bit want_v;
        for (int i = 0; i < 8; i++) step(1, 32'h11 * (i + 1), 0, 0);
        tests++;
        if (count !== 4'd8 || full !== 1'b1 || status !== exp_status()) begin
            fails++;
            $display("FAIL fill_full got %b want %b", status, exp_status());
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            want   = FWFT ? 32'h11 * (i + 2) : 32'h11 * (i + 1);
            want_v = FWFT ? (i < 7) : 1'b1;
            tests++;
            if (rd_valid !== want_v || (want_v && rd_data !== want)) begin
                fails++;
                $display("FAIL drain_%0d got %b/%h want %b/%h", i, rd_valid, rd_data, want_v, want);
            end
        end
        tests++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            fails++;
            $display("FAIL drain_empty got %b/%0d want 1/0", empty, count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        bit want_v;
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            tests++;
            if (status !== exp_status() || ((!FWFT || rv_m) && rd_data !== rd_m)) begin
                fails++;
                $display("FAIL wrap_pre_%0d got %b/%h want %b/%h", i, status, rd_data, exp_status(), rd_m);
            end
        end
        for (int i = 0; i < 8; i++) step(1, 32'hA0 + i, 0, 0);
        tests++;
        if (full !== 1'b1 || count !== 4'd8) begin
            fails++;
            $display("FAIL wrap_full got %b/%0d want 1/8", full, count);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            want   = FWFT ? 32'hA1 + i : 32'hA0 + i;
            want_v = FWFT ? (i < 7) : 1'b1;
            tests++;
            if (rd_valid !== want_v || (want_v && rd_data !== want)) begin
                fails++;
                $display("FAIL wrap_rd_%0d got %b/%h want %b/%h", i, rd_valid, rd_data, want_v, want);
            end
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) step(1, 32'h100 + i, 0, 0);
        step(1, 32'hFF, 1, 0);
        tests++;
        if (count !== 4'd8 || overflow !== 1'b0 || rd_valid !== 1'b1 ||
            rd_data !== (FWFT ? 32'h101 : 32'h100)) begin
            fails++;
            $display("FAIL full_rw got cnt=%0d ovf=%b rv=%b d=%h want cnt=8 ovf=0 rv=1",
                     count, overflow, rd_valid, rd_data);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            tests++;
            if (status !== exp_status() || ((!FWFT || rv_m) && rd_data !== rd_m)) begin
                fails++;
                $display("FAIL full_rw_drain_%0d got %b/%h want %b/%h", i, status, rd_data, exp_status(), rd_m);
            end
        end
        tests++;
        if (!FWFT && rd_data !== 32'hFF) begin
            fails++;
            $display("FAIL full_rw_last got %h want ff", rd_data);
        end
    endtask

    task automatic test_overflow_clr();
        for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
        step(1, 32'hDEAD, 0, 0);
        tests++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            fails++;
            $display("FAIL overflow got %b/%0d want 1/8", overflow, count);
        end
        step(1, 32'h1, 1, 1);
        tests++;
        if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL clr got cnt=%0d ovf=%b emp=%b rv=%b want 0/0/1/0", count, overflow, empty, rd_valid);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0);
        tests++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL underflow got unf=%b rv=%b cnt=%0d want 1/0/0", underflow, rd_valid, count);
        end
        step(1, 32'h55, 1, 0);
        tests++;
        if (count !== 4'd1 || underflow !== 1'b1 || status !== exp_status()) begin
            fails++;
            $display("FAIL underflow_rw got %b want %b", status, exp_status());
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
        #2 rst = 0;
        #1;
        tests++;
        if (status !== RST_ST || (!FWFT && rd_data !== 32'h0)) begin
            fails++;
            $display("FAIL reset_mid got %b/%h want %b/0", status, rd_data, RST_ST);
        end
        model_reset();
        #2 rst = 1;
        step(0, 0, 1, 0);
        tests++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_read got unf=%b rv=%b cnt=%0d want 1/0/0", underflow, rd_valid, count);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit w, r, c;
        for (int i = 0; i < 600; i++) begin
            w = (i % 200 < 100) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            r = (i % 200 < 100) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            c = ($urandom % 50 == 0);
            step(w, $urandom, r, c);
            tests++;
            if (status !== exp_status() || ((!FWFT || rv_m) && rd_data !== rd_m)) begin
                fails++;
                $display("FAIL random_%0d got %b/%h want %b/%h", i, status, rd_data, exp_status(), rd_m);
            end
        end
    endtask

    task automatic test_levels16();
        for (int k = 1; k <= 12; k++) begin
            step2(1, 8'(k), 0);
            tests++;
            if (count2 !== 5'(k) || almost_full2 !== (k >= 12) || almost_empty2 !== (k <= 3)) begin
                fails++;
                $display("FAIL levels16_%0d got cnt=%0d af=%b ae=%b want %0d/%b/%b",
                         k, count2, almost_full2, almost_empty2, k, k >= 12, k <= 3);
            end
        end
        for (int k = 0; k < 6; k++) step2(0, 0, 1);
        tests++;
        if (count2 !== 5'd6 || almost_full2 !== 1'b0 || almost_empty2 !== 1'b0) begin
            fails++;
            $display("FAIL levels16_six got cnt=%0d af=%b ae=%b want 6/0/0", count2, almost_full2, almost_empty2);
        end
        #2 rst = 0;
        #1;
        tests++;
        if (status2 !== RST_ST2 || (!FWFT && rd_data2 !== 8'h0)) begin
            fails++;
            $display("FAIL reset16 got %b/%h want %b/0", status2, rd_data2, RST_ST2);
        end
        model_reset();
        #2 rst = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_overflow_clr();
        test_underflow();
        test_reset_mid();
        test_random();
        test_levels16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: entry count, a power of two, at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 clk  input  1: clock, rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-low.
REQ-007 clr  input  1: synchronous flush.
REQ-008 write  input  1: write request.
REQ-009 wrData  input  WIDTH: write data.
REQ-010 read  input  1: read request.
REQ-011 rdData  output  WIDTH: read data.
REQ-012 rd_valid  output  1: rdData qualifier.
REQ-013 full  output  1: count == DEPTH.
REQ-014 empty  output  1: count == 0.
REQ-015 almost_full  output  1: count >= AF_LEVEL.
REQ-016 almost_empty  output  1: count <= AE_LEVEL.
REQ-017 count  output  $clog2(DEPTH)+1: current occupancy.
REQ-018 overflow  output  1: sticky flag, write dropped.
REQ-019 underflow  output  1: sticky flag, read on empty.

Function
REQ-020 Write is accepted iff write && (!full || read_accepted); data is stored at w_ptr and w_ptr increments.
REQ-021 Read is accepted iff read && !empty; r_ptr increments.
REQ-022 Both pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra logic.
REQ-023 count changes by +1 on write-only acceptance, by -1 on read-only acceptance, and is unchanged when both are accepted or neither is.
REQ-024 When full, a simultaneous read and write are both accepted and count stays DEPTH.
REQ-025 When empty, a simultaneous read and write: read is rejected, write is accepted, count becomes 1, and underflow is set.
REQ-026 full, empty, almost_full and almost_empty are combinational from the count register.
REQ-027 overflow is set on write && full && !read; it holds until clr or reset.
REQ-028 underflow is set on read && empty; it holds until clr or reset.
REQ-029 clr = 1 resets the pointers, count and sticky flags to 0 on the next edge, overrides read and write in the same cycle, drops rd_valid, and leaves memory contents undefined.
REQ-030 Standard mode: an accepted read loads mem[r_ptr] into the rdData register at the same edge; rd_valid is 1 for exactly that following cycle.
REQ-031 When no read is accepted, rdData holds its last value.

Reset
REQ-032 rst low asynchronously clears w_ptr, r_ptr, count, overflow, underflow, rd_valid and rdData to 0.
REQ-033 After reset, empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-034 Reset asserted mid-operation discards all contents; the first read after release is rejected as empty.
REQ-035 Memory array is not reset.

Configuration
REQ-036 Macro PARAM_SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
REQ-037 With the macro defined: rdData = mem[r_ptr] combinationally and rd_valid = !empty; read pops the head at the edge, giving zero-cycle read latency.
REQ-038 Without the macro: registered one-cycle read latency per REQ-030.
REQ-039 All other requirements are identical in both modes.

Verification
REQ-040 Fill and drain, defaults: write 8 values 0x11..0x88 -> full = 1 and count = 8 after the 8th edge; 8 reads return 0x11..0x88 in order with rd_valid; then empty = 1.
REQ-041 Wrap: write 5, read 5, write 8 (0xA0..0xA7) -> pointers wrap; reads return 0xA0..0xA7.
REQ-042 Full with simultaneous read and write (wrData 0xFF) -> count stays 8, the oldest word is returned, 0xFF becomes the last entry, and overflow = 0.
REQ-043 Write while full without read -> overflow = 1 and count = 8; clr -> count = 0, overflow = 0, empty = 1.
REQ-044 Read on empty -> underflow = 1, rd_valid = 0, count = 0; read and write on empty -> count = 1, underflow = 1.
REQ-045 DEPTH = 16, AF_LEVEL = 12, AE_LEVEL = 3: almost_full rises when count reaches 12 and almost_empty falls when count reaches 4; rst pulse with count = 6 -> all outputs at reset values immediately.
